// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write port arbiter.
package regfile_pkg;

  localparam int unsigned REG_W = 64;
  localparam int unsigned NREG  = 32;
  localparam logic [4:0]  XZR   = 5'd31;

  typedef struct packed {
    logic [4:0]       wa;
    logic [REG_W-1:0] wd;
  } wr_req_t;

endpackage

// File: rtl/wr_fifo.sv
// Small synchronous FIFO of register-file write requests.
module wr_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  wr_req_t                    wdata,
  output wr_req_t                    rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wr_req_t         mem [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between writeback and queued multicycle results,
// with a starvation bound and a pending-write scoreboard for decode.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [4:0]        wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              wb_stall,
  input  logic              mc_issue,
  input  logic [4:0]        mc_issue_rd,
  output logic              issue_ok,
  input  logic              mc_valid,
  input  logic [4:0]        mc_wa,
  input  logic [DATA_W-1:0] mc_wd,
  output logic              mc_ready,
  output logic              we3,
  output logic [4:0]        wa3,
  output logic [DATA_W-1:0] wd3,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic              busy1,
  output logic              busy2
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  wr_req_t         mc_req, head;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [StW-1:0]  starve_q, starve_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            forced;

  assign mc_req    = '{wa: mc_wa, wd: mc_wd};
  assign mc_ready  = reset & (fifo_count < CntW'(FIFO_DEPTH));
  assign fifo_push = mc_valid & mc_ready & ~fifo_full;

  wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (mc_req),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign forced = ~fifo_empty & (starve_q == StW'(STARVE_MAX));

  always_comb begin
    we3      = 1'b0;
    wa3      = '0;
    wd3      = '0;
    wb_stall = 1'b0;
    fifo_pop = 1'b0;
    if (reset) begin
      if (forced) begin
        fifo_pop = 1'b1;
        wa3      = head.wa;
        wd3      = head.wd;
        wb_stall = wb_we;
      end else if (wb_we) begin
        wa3 = wb_wa;
        wd3 = wb_wd;
      end else if (!fifo_empty) begin
        fifo_pop = 1'b1;
        wa3      = head.wa;
        wd3      = head.wd;
      end
      // XZR writes are granted and consumed but never reach the regfile.
      we3 = (fifo_pop | wb_we) & (wa3 != XZR);
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (wb_we && (starve_q != StW'(STARVE_MAX))) begin
      starve_d = starve_q + StW'(1);
    end
  end

  // Set after clear so a same-cycle reissue of the committing register wins.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) pending_d[head.wa] = 1'b0;
    if (mc_issue && (mc_issue_rd != XZR)) pending_d[mc_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  assign busy1    = reset & pending_q[ra1] & ~(fifo_pop & (head.wa == ra1));
  assign busy2    = reset & pending_q[ra2] & ~(fifo_pop & (head.wa == ra2));
  assign issue_ok = ~reset | ~pending_q[mc_issue_rd];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus randomized bench for regfile_wr_arbiter against a queue-based model.
module tb_regfile_wr_arbiter;

  localparam int STARVE = 4;
  localparam int DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we, mc_issue, mc_valid;
  logic [4:0]  wb_wa, mc_issue_rd, mc_wa, ra1, ra2, wa3;
  logic [63:0] wb_wd, mc_wd, wd3;
  logic        wb_stall, issue_ok, mc_ready, we3, busy1, busy2;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .DATA_W     (64),
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_we       (wb_we),
    .wb_wa       (wb_wa),
    .wb_wd       (wb_wd),
    .wb_stall    (wb_stall),
    .mc_issue    (mc_issue),
    .mc_issue_rd (mc_issue_rd),
    .issue_ok    (issue_ok),
    .mc_valid    (mc_valid),
    .mc_wa       (mc_wa),
    .mc_wd       (mc_wd),
    .mc_ready    (mc_ready),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .ra1         (ra1),
    .ra2         (ra2),
    .busy1       (busy1),
    .busy2       (busy2)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [4:0]  wa;
    logic [63:0] wd;
  } ent_t;

  ent_t        mq[$];
  bit          pend[32];
  int          starve;
  logic        e_we, e_stall, e_pop;
  logic [4:0]  e_wa;
  logic [63:0] e_wd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_outputs();
    e_we = 0; e_stall = 0; e_pop = 0; e_wa = 0; e_wd = 0;
    if (reset) begin
      if (mq.size() > 0 && starve == STARVE) begin
        e_pop = 1; e_wa = mq[0].wa; e_wd = mq[0].wd; e_stall = wb_we;
      end else if (wb_we) begin
        e_wa = wb_wa; e_wd = wb_wd;
      end else if (mq.size() > 0) begin
        e_pop = 1; e_wa = mq[0].wa; e_wd = mq[0].wd;
      end
      e_we = (e_pop || wb_we) && (e_wa != 5'd31);
    end
  endtask

  task automatic sample();
    #2;
    model_outputs();
    chk("we3", we3, e_we);
    if (e_we || !reset) begin
      chk("wa3", wa3, e_wa);
      chk("wd3", wd3, e_wd);
    end
    chk("wb_stall", wb_stall, e_stall);
    chk("mc_ready", mc_ready, reset && mq.size() < DEPTH);
    chk("busy1", busy1, reset && pend[ra1] && !(e_pop && e_wa == ra1));
    chk("busy2", busy2, reset && pend[ra2] && !(e_pop && e_wa == ra2));
    chk("issue_ok", issue_ok, !reset || !pend[mc_issue_rd]);
  endtask

  task automatic tick();
    bit ne;
    bit push_ok;
    @(posedge clk);
    ne      = mq.size() > 0;
    push_ok = mc_valid && mq.size() < DEPTH;
    if (!reset) begin
      mq.delete();
      foreach (pend[i]) pend[i] = 0;
      starve = 0;
    end else begin
      if (!ne || e_pop) starve = 0;
      else if (wb_we && starve < STARVE) starve++;
      if (e_pop) begin
        pend[mq[0].wa] = 0;
        void'(mq.pop_front());
      end
      if (push_ok) mq.push_back('{wa: mc_wa, wd: mc_wd});
      if (mc_issue && mc_issue_rd != 5'd31) pend[mc_issue_rd] = 1;
    end
    #1;
  endtask

  task automatic quiet();
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    mc_issue = 0; mc_issue_rd = 0;
    mc_valid = 0; mc_wa = 0; mc_wd = 0;
    ra1 = 0; ra2 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    foreach (pend[i]) pend[i] = 0;
    starve = 0;
    quiet();
    reset = 0;
    #1;
    sample(); tick();
    sample(); chk("rst_issue_ok", issue_ok, 1); tick();
    reset = 1;

    // Idle port: issue X5, then its result while writeback is idle.
    mc_issue = 1; mc_issue_rd = 5; sample(); tick();
    mc_issue = 0; mc_valid = 1; mc_wa = 5; mc_wd = 64'h1234; ra1 = 5;
    sample(); chk("idle_busy_pre", busy1, 1); tick();
    mc_valid = 0;
    sample();
    chk("idle_we3", we3, 1); chk("idle_wa3", wa3, 5); chk("idle_wd3", wd3, 64'h1234);
    chk("idle_busy_commit", busy1, 0);
    tick();
    sample(); chk("idle_busy_post", busy1, 0); tick();

    // Starvation: one queued result under continuous writeback.
    quiet();
    wb_we = 1; wb_wa = 3; wb_wd = 64'hbeef;
    mc_valid = 1; mc_wa = 9; mc_wd = 64'haa;
    for (int i = 0; i < 7; i++) begin
      sample();
      chk("starve_stall", wb_stall, i == 5);
      chk("starve_wa3", wa3, (i == 5) ? 5'd9 : 5'd3);
      tick();
      mc_valid = 0;
    end

    // FIFO full: three back-to-back results with writeback held.
    acc = 0;
    mc_valid = 1;
    for (int i = 0; i < 7; i++) begin
      mc_wa = 5'(10 + acc); mc_wd = 64'(100 + acc);
      sample();
      chk("full_ready", mc_ready, (i < 2) || (i >= 6));
      if (mc_ready) acc++;
      tick();
    end
    chk("full_accepts", acc, 3);
    quiet();
    for (int i = 0; i < 4; i++) begin sample(); tick(); end

    // XZR: no pending bit, silent pop, silent writeback.
    mc_issue = 1; mc_issue_rd = 31; sample(); tick();
    mc_issue = 0; mc_valid = 1; mc_wa = 31; mc_wd = 64'h55; ra1 = 31;
    sample(); chk("xzr_busy", busy1, 0); tick();
    mc_valid = 0;
    sample(); chk("xzr_pop_we3", we3, 0); tick();
    wb_we = 1; wb_wa = 31; wb_wd = 64'h77;
    sample(); chk("xzr_wb_we3", we3, 0); chk("xzr_wb_stall", wb_stall, 0); tick();
    quiet();

    // Same-cycle set/clear on X7.
    mc_issue = 1; mc_issue_rd = 7; sample(); tick();
    mc_issue = 0; mc_valid = 1; mc_wa = 7; mc_wd = 64'h700; sample(); tick();
    mc_valid = 0; mc_issue = 1; mc_issue_rd = 7; ra1 = 7;
    sample(); chk("setclr_we3", we3, 1); chk("setclr_busy_commit", busy1, 0); tick();
    mc_issue = 0;
    sample(); chk("setclr_busy_after", busy1, 1); tick();
    quiet();

    // Reset mid-operation with two queued entries and three pending bits.
    for (int r = 1; r <= 3; r++) begin
      mc_issue = 1; mc_issue_rd = 5'(r); sample(); tick();
    end
    mc_issue = 0; wb_we = 1; wb_wa = 4; wb_wd = 64'h44;
    mc_valid = 1; mc_wa = 1; mc_wd = 64'h11; sample(); tick();
    mc_wa = 2; mc_wd = 64'h22; sample(); tick();
    mc_valid = 0; reset = 0;
    sample(); chk("rst_mid_we3", we3, 0); chk("rst_mid_ready", mc_ready, 0); tick();
    reset = 1; quiet(); ra1 = 1; ra2 = 2; mc_issue_rd = 3;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_post_we3", we3, 0); chk("rst_post_ready", mc_ready, 1);
      chk("rst_post_busy1", busy1, 0); chk("rst_post_issue_ok", issue_ok, 1);
      tick();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      reset       = ($urandom_range(0, 79) != 0);
      wb_we       = ($urandom_range(0, 2) != 0);
      wb_wa       = 5'($urandom_range(0, 31));
      wb_wd       = {$urandom, $urandom};
      mc_issue_rd = 5'($urandom_range(0, 31));
      mc_issue    = ($urandom_range(0, 2) == 0) && !pend[mc_issue_rd];
      mc_valid    = ($urandom_range(0, 1) == 0);
      mc_wa       = 5'($urandom_range(0, 31));
      mc_wd       = {$urandom, $urandom};
      ra1         = (mq.size() > 0 && $urandom_range(0, 1) == 0) ? mq[0].wa
                                                                 : 5'($urandom_range(0, 31));
      ra2         = 5'($urandom_range(0, 31));
      sample();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
